// File: rtl/fmap_pkg.sv
// Geometry helpers and FSM state type shared by the feature-map streamer and
// the input shift register, so both ends derive the same FILL threshold.
package fmap_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DONE   = 2'd2
    } fmap_state_e;

    function automatic int calc_hp(input int h, input int pad);
        return h + 2 * pad;
    endfunction

    function automatic int calc_wp(input int w, input int pad);
        return w + 2 * pad;
    endfunction

    function automatic int calc_total(input int h, input int w, input int pad);
        return calc_hp(h, pad) * calc_wp(w, pad);
    endfunction

    function automatic int calc_in_window_h(input int pool_h, input int stride_h, input int fh);
        return (pool_h - 1) * stride_h + fh;
    endfunction

    function automatic int calc_in_window_w(input int pool_w, input int stride_w, input int fw);
        return (pool_w - 1) * stride_w + fw;
    endfunction

    // Pixels that must be shifted in before the first full pooling window exists.
    function automatic int calc_fill(input int w, input int pad, input int fh,
                                     input int pool_h, input int stride_h);
        return calc_wp(w, pad) * fh + calc_in_window_h(pool_h, stride_h, fh);
    endfunction

    function automatic int clog2_min1(input int v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/fmap_pad_counter.sv
// Raster position over the padded frame; flags pad positions and the final
// (HP-1, WP-1) position.
module fmap_pad_counter
    import fmap_pkg::*;
#(
    parameter int H   = 4,
    parameter int W   = 4,
    parameter int PAD = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic advance,
    output logic is_pad,
    output logic last_pos
);

    localparam int HP = calc_hp(H, PAD);
    localparam int WP = calc_wp(W, PAD);
    localparam int RW = clog2_min1(HP);
    localparam int CW = clog2_min1(WP);

    logic [RW-1:0] r_row;
    logic [CW-1:0] r_col;
    logic          w_col_last;
    int            w_row_i;
    int            w_col_i;

    assign w_col_last = (r_col == CW'(WP - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_row <= '0;
            r_col <= '0;
        end else if (clear) begin
            r_row <= '0;
            r_col <= '0;
        end else if (advance) begin
            if (w_col_last) begin
                r_col <= '0;
                r_row <= r_row + RW'(1);
            end else begin
                r_col <= r_col + CW'(1);
            end
        end
    end

    // Signed compares keep PAD=0 legal without constant-comparison hazards.
    assign w_row_i  = int'(r_row);
    assign w_col_i  = int'(r_col);
    assign is_pad   = (w_row_i < PAD) || (w_row_i >= PAD + H) ||
                      (w_col_i < PAD) || (w_col_i >= PAD + W);
    assign last_pos = (r_row == RW'(HP - 1)) && w_col_last;

endmodule

// File: rtl/fmap_in_streamer.sv
// Feeds the input feature-map shift register: inserts zero padding around
// raw raster-order pixels and flags window-valid once the buffer is full.
module fmap_in_streamer
    import fmap_pkg::*;
#(
    parameter int H        = 4,
    parameter int W        = 4,
    parameter int D        = 8,
    parameter int FH       = 3,
    parameter int FW       = 3,
    parameter int POOL_H   = 2,
    parameter int POOL_W   = 2,
    parameter int PAD      = 1,
    parameter int STRIDE_H = 1,
    parameter int STRIDE_W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         src_valid,
    input  logic [D-1:0] src_data,
    output logic         src_ready,
    output logic [1:0]   in_en,
    output logic [D-1:0] data_in,
    output logic         busy,
    output logic         done
);

    localparam int HP          = calc_hp(H, PAD);
    localparam int WP          = calc_wp(W, PAD);
    localparam int TOTAL       = calc_total(H, W, PAD);
    localparam int IN_WINDOW_H = calc_in_window_h(POOL_H, STRIDE_H, FH);
    localparam int IN_WINDOW_W = calc_in_window_w(POOL_W, STRIDE_W, FW);
    localparam int FILL        = calc_fill(W, PAD, FH, POOL_H, STRIDE_H);
    localparam int EW          = clog2_min1(TOTAL + 1);

    // A pooling window larger than the padded frame can never become valid.
    if (IN_WINDOW_H > HP || IN_WINDOW_W > WP) begin : g_bad_geometry
        $error("fmap_in_streamer: pooling input window exceeds padded frame");
    end

    fmap_state_e    r_state;
    logic [EW-1:0]  r_emit;
    logic [1:0]     r_in_en;
    logic [D-1:0]   r_data;
    logic           r_done;
    logic           w_is_pad;
    logic           w_last;
    logic           w_clear;
    logic           w_emit;
    logic           w_win;

    assign w_clear = (r_state == ST_IDLE) && start;
    assign w_emit  = (r_state == ST_STREAM) && (w_is_pad || src_valid);
    assign w_win   = (int'(r_emit) >= FILL);

    fmap_pad_counter #(
        .H   (H),
        .W   (W),
        .PAD (PAD)
    ) u_pos (
        .clk      (clk),
        .rst      (rst),
        .clear    (w_clear),
        .advance  (w_emit),
        .is_pad   (w_is_pad),
        .last_pos (w_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_emit  <= '0;
            r_in_en <= 2'b00;
            r_data  <= '0;
            r_done  <= 1'b0;
        end else begin
            r_in_en <= 2'b00;
            r_done  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state <= ST_STREAM;
                        r_emit  <= '0;
                    end
                end
                ST_STREAM: begin
                    // A stall leaves data_in and all counters untouched.
                    if (w_emit) begin
                        r_in_en <= {w_win, 1'b1};
                        r_data  <= w_is_pad ? '0 : src_data;
                        r_emit  <= r_emit + EW'(1);
                        if (w_last) r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b1;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign src_ready = (r_state == ST_STREAM) && !w_is_pad;
    assign busy      = (r_state == ST_STREAM);
    assign in_en     = r_in_en;
    assign data_in   = r_data;
    assign done      = r_done;

endmodule

// File: tb/tb_fmap_in_streamer.sv
// Bench for fmap_in_streamer: default 4x4/PAD=1 instance plus a 6x6/PAD=0
// instance, checked against a raster-order padding model.
module tb_fmap_in_streamer;

    localparam int D = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start_a, valid_a, ready_a, busy_a, done_a;
    logic [D-1:0] sdata_a, din_a;
    logic [1:0]   en_a;
    logic         start_b, valid_b, ready_b, busy_b, done_b;
    logic [D-1:0] sdata_b, din_b;
    logic [1:0]   en_b;

    int total = 0;
    int bad   = 0;

    logic [D-1:0] src_q[$];
    logic [D-1:0] exp_data[$], cap_data[$], sav_data[$];
    logic [1:0]   exp_en[$], cap_en[$];
    int           cap_cyc[$];
    int           hs, done_cnt, done_cyc, stalls, nrdy, timeout, aborted;
    logic [1:0]   ab_en;
    logic [D-1:0] ab_din;
    logic         ab_ready, ab_busy, ab_done;

    always #5 clk = ~clk;

    fmap_in_streamer u_dut_a (
        .clk(clk), .rst(rst), .start(start_a), .src_valid(valid_a), .src_data(sdata_a),
        .src_ready(ready_a), .in_en(en_a), .data_in(din_a), .busy(busy_a), .done(done_a)
    );

    fmap_in_streamer #(.H(6), .W(6), .PAD(0)) u_dut_b (
        .clk(clk), .rst(rst), .start(start_b), .src_valid(valid_b), .src_data(sdata_b),
        .src_ready(ready_b), .in_en(en_b), .data_in(din_b), .busy(busy_b), .done(done_b)
    );

    // Geometry of each instance: 0 = defaults, 1 = 6x6 without padding.
    function automatic int g_h(int s);   return s ? 6 : 4; endfunction
    function automatic int g_w(int s);   return s ? 6 : 4; endfunction
    function automatic int g_pad(int s); return s ? 0 : 1; endfunction
    function automatic int g_hp(int s);  return g_h(s) + 2 * g_pad(s); endfunction
    function automatic int g_wp(int s);  return g_w(s) + 2 * g_pad(s); endfunction
    function automatic int g_fill(int s); return g_wp(s) * 3 + ((2 - 1) * 1 + 3); endfunction

    function automatic logic [1:0]   f_en(int s);    return s ? en_b : en_a;       endfunction
    function automatic logic [D-1:0] f_din(int s);   return s ? din_b : din_a;     endfunction
    function automatic logic         f_ready(int s); return s ? ready_b : ready_a; endfunction
    function automatic logic         f_busy(int s);  return s ? busy_b : busy_a;   endfunction
    function automatic logic         f_done(int s);  return s ? done_b : done_a;   endfunction

    task automatic drive(input int s, input logic st, input logic v, input logic [D-1:0] d);
        if (s == 0) begin start_a = st; valid_a = v; sdata_a = d; end
        else        begin start_b = st; valid_b = v; sdata_b = d; end
    endtask

    task automatic fill_src(input int n, input bit counting);
        src_q.delete();
        for (int i = 0; i < n; i++) src_q.push_back(counting ? D'(i + 1) : D'($urandom));
    endtask

    // Reference: walk the padded frame in raster order, zeros on the border,
    // source pixels in order inside, window-valid from emit index FILL on.
    task automatic build_exp(input int s);
        int k, idx;
        bit pad;
        exp_data.delete();
        exp_en.delete();
        k = 0;
        idx = 0;
        for (int r = 0; r < g_hp(s); r++) begin
            for (int c = 0; c < g_wp(s); c++) begin
                pad = (r < g_pad(s)) || (r >= g_pad(s) + g_h(s)) ||
                      (c < g_pad(s)) || (c >= g_pad(s) + g_w(s));
                exp_data.push_back(pad ? '0 : src_q[k]);
                if (!pad) k++;
                exp_en.push_back(idx >= g_fill(s) ? 2'b11 : 2'b01);
                idx++;
            end
        end
    endtask

    function automatic int diff_data();
        if (cap_data.size() != exp_data.size()) return 9999;
        foreach (exp_data[i]) if (cap_data[i] !== exp_data[i]) return i;
        return -1;
    endfunction

    function automatic int diff_en();
        if (cap_en.size() != exp_en.size()) return 9999;
        foreach (exp_en[i]) if (cap_en[i] !== exp_en[i]) return i;
        return -1;
    endfunction

    // bp: 0 = always valid, 1 = three-cycle drop at source pixel 5 plus random
    // valid on pad positions, 2 = random valid everywhere.
    task automatic run_frame(input int s, input int bp, input bit hold_start,
                             input int abort_at, input int post_max);
        int   post, drops, idx;
        logic st, v;
        logic [D-1:0] d;
        cap_en.delete(); cap_data.delete(); cap_cyc.delete();
        hs = 0; done_cnt = 0; done_cyc = -1; stalls = 0; nrdy = 0;
        timeout = 0; aborted = 0;
        post = 0; drops = 3; idx = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            if (f_en(s) != 2'b00) begin
                cap_en.push_back(f_en(s));
                cap_data.push_back(f_din(s));
                cap_cyc.push_back(cyc);
            end
            if (f_done(s)) begin done_cnt++; done_cyc = cyc; end
            if (done_cnt > 0) post++;
            if (done_cnt > 0 && post > post_max) break;
            if (abort_at >= 0 && cap_en.size() == abort_at) begin
                #2 rst = 1'b1;
                #1;
                ab_en = f_en(s); ab_din = f_din(s); ab_ready = f_ready(s);
                ab_busy = f_busy(s); ab_done = f_done(s);
                aborted = 1;
                break;
            end
            st = (cyc == 0) || (hold_start && done_cnt == 0);
            v = 1'b1;
            if (f_ready(s)) begin
                if (bp == 1 && idx == 4 && drops > 0) begin v = 1'b0; drops--; end
                else if (bp == 2) v = ($urandom_range(0, 3) != 0);
            end else if (bp != 0) begin
                v = logic'($urandom_range(0, 1));
            end
            d = (idx < src_q.size()) ? src_q[idx] : D'($urandom);
            if (f_ready(s) && !v) stalls++;
            if (f_busy(s) && !f_ready(s)) nrdy++;
            if (v && f_ready(s)) begin hs++; idx++; end
            drive(s, st, v, d);
        end
        if (done_cnt == 0 && aborted == 0) timeout = 1;
        drive(s, 1'b0, 1'b0, '0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive(0, logic'($urandom_range(0, 1)), logic'($urandom_range(0, 1)), D'($urandom));
            drive(1, logic'($urandom_range(0, 1)), logic'($urandom_range(0, 1)), D'($urandom));
        end
        @(negedge clk);
        total++; if (en_a !== 2'b00) begin bad++; $display("FAIL rst_in_en: got %b want 00", en_a); end
        total++; if (din_a !== '0) begin bad++; $display("FAIL rst_data_in: got %h want 00", din_a); end
        total++; if ({ready_a, busy_a, done_a} !== 3'b000)
            begin bad++; $display("FAIL rst_ctl: got rdy/busy/done=%b want 000", {ready_a, busy_a, done_a}); end
        total++; if ({en_b, ready_b, busy_b, done_b} !== 5'b0)
            begin bad++; $display("FAIL rst_b: got %b want 00000", {en_b, ready_b, busy_b, done_b}); end
        drive(0, 1'b0, 1'b0, '0);
        drive(1, 1'b0, 1'b0, '0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_default_frame();
        fill_src(16, 1'b1);
        build_exp(0);
        run_frame(0, 0, 1'b0, -1, 4);
        total++; if (timeout != 0) begin bad++; $display("FAIL dflt_timeout: got no done want done"); end
        total++; if (cap_en.size() != 36) begin bad++; $display("FAIL dflt_count: got %0d want 36", cap_en.size()); end
        total++; if (diff_data() != -1) begin bad++; $display("FAIL dflt_data: first diff at %0d want none", diff_data()); end
        total++; if (diff_en() != -1) begin bad++; $display("FAIL dflt_en: first diff at %0d want none", diff_en()); end
        total++; if (hs != 16) begin bad++; $display("FAIL dflt_handshakes: got %0d want 16", hs); end
        total++; if (done_cnt != 1) begin bad++; $display("FAIL dflt_done_cnt: got %0d want 1", done_cnt); end
        if (cap_en.size() == 36) begin
            total++; if (cap_data[6] !== 8'd0 || cap_data[7] !== 8'd1 || cap_data[28] !== 8'd16)
                begin bad++; $display("FAIL dflt_landmarks: got e6=%0d e7=%0d e28=%0d want 0 1 16",
                                      cap_data[6], cap_data[7], cap_data[28]); end
            total++; if (cap_en[21] !== 2'b01 || cap_en[22] !== 2'b11)
                begin bad++; $display("FAIL dflt_fill: got e21=%b e22=%b want 01 11", cap_en[21], cap_en[22]); end
            total++; if (cap_cyc[35] - cap_cyc[0] + 1 != 36)
                begin bad++; $display("FAIL dflt_contig: got span %0d want 36", cap_cyc[35] - cap_cyc[0] + 1); end
            total++; if (cap_cyc[0] != 2) begin bad++; $display("FAIL dflt_latency: got %0d want 2", cap_cyc[0]); end
            total++; if (done_cyc != cap_cyc[35] + 1)
                begin bad++; $display("FAIL dflt_done_time: got %0d want %0d", done_cyc, cap_cyc[35] + 1); end
        end
    endtask

    task automatic test_backpressure();
        int span;
        fill_src(16, 1'b0);
        build_exp(0);
        run_frame(0, 1, 1'b0, -1, 4);
        span = (cap_cyc.size() > 0) ? cap_cyc[cap_cyc.size() - 1] - cap_cyc[0] + 1 : 0;
        total++; if (diff_data() != -1) begin bad++; $display("FAIL bp_data: first diff at %0d want none", diff_data()); end
        total++; if (diff_en() != -1) begin bad++; $display("FAIL bp_en: first diff at %0d want none", diff_en()); end
        total++; if (stalls != 3) begin bad++; $display("FAIL bp_stalls: got %0d want 3", stalls); end
        total++; if (span != 36 + stalls) begin bad++; $display("FAIL bp_span: got %0d want %0d", span, 36 + stalls); end
        total++; if (hs != 16 || done_cnt != 1)
            begin bad++; $display("FAIL bp_hs_done: got hs=%0d done=%0d want 16 1", hs, done_cnt); end
    endtask

    task automatic test_random_stalls();
        int span;
        for (int rep = 0; rep < 3; rep++) begin
            fill_src(16, 1'b0);
            build_exp(0);
            run_frame(0, 2, 1'b0, -1, 2);
            span = (cap_cyc.size() > 0) ? cap_cyc[cap_cyc.size() - 1] - cap_cyc[0] + 1 : 0;
            total++; if (diff_data() != -1 || diff_en() != -1)
                begin bad++; $display("FAIL rnd_seq%0d: diff data@%0d en@%0d want none", rep, diff_data(), diff_en()); end
            total++; if (span != 36 + stalls)
                begin bad++; $display("FAIL rnd_span%0d: got %0d want %0d", rep, span, 36 + stalls); end
            total++; if (hs != 16 || done_cnt != 1)
                begin bad++; $display("FAIL rnd_hs_done%0d: got hs=%0d done=%0d want 16 1", rep, hs, done_cnt); end
        end
    endtask

    task automatic test_back_to_back();
        fill_src(16, 1'b0);
        build_exp(0);
        // start held high through STREAM and DONE; released as done is seen
        run_frame(0, 0, 1'b1, -1, 0);
        total++; if (diff_data() != -1 || diff_en() != -1)
            begin bad++; $display("FAIL b2b_first: diff data@%0d en@%0d want none", diff_data(), diff_en()); end
        sav_data = cap_data;
        run_frame(0, 0, 1'b0, -1, 4);
        total++; if (cap_data != sav_data)
            begin bad++; $display("FAIL b2b_repeat: got %0d emits want identical %0d", cap_data.size(), sav_data.size()); end
        total++; if (diff_en() != -1) begin bad++; $display("FAIL b2b_en: first diff at %0d want none", diff_en()); end
        total++; if (cap_cyc.size() == 0 || cap_cyc[0] != 2)
            begin bad++; $display("FAIL b2b_restart: got first emit cyc %0d want 2",
                                  cap_cyc.size() ? cap_cyc[0] : -1); end
        total++; if (done_cnt != 1) begin bad++; $display("FAIL b2b_done: got %0d want 1", done_cnt); end
    endtask

    task automatic test_reset_mid_frame();
        int stray;
        fill_src(16, 1'b0);
        run_frame(0, 0, 1'b0, 10, 4);
        total++; if (aborted != 1) begin bad++; $display("FAIL mid_reached: got %0d want 1", aborted); end
        total++; if ({ab_en, ab_din, ab_ready, ab_busy, ab_done} !== '0)
            begin bad++; $display("FAIL mid_async_clear: got en=%b d=%h r=%b b=%b dn=%b want all 0",
                                  ab_en, ab_din, ab_ready, ab_busy, ab_done); end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        stray = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done_a || en_a != 2'b00) stray++;
        end
        total++; if (stray != 0) begin bad++; $display("FAIL mid_no_done: got %0d active cycles want 0", stray); end
        fill_src(16, 1'b0);
        build_exp(0);
        run_frame(0, 0, 1'b0, -1, 4);
        total++; if (diff_data() != -1 || diff_en() != -1)
            begin bad++; $display("FAIL mid_new_frame: diff data@%0d en@%0d want none", diff_data(), diff_en()); end
        total++; if (hs != 16 || done_cnt != 1)
            begin bad++; $display("FAIL mid_hs_done: got hs=%0d done=%0d want 16 1", hs, done_cnt); end
    endtask

    task automatic test_nopad();
        fill_src(36, 1'b0);
        build_exp(1);
        run_frame(1, 0, 1'b0, -1, 4);
        total++; if (nrdy != 0) begin bad++; $display("FAIL nopad_ready: got %0d busy-not-ready cycles want 0", nrdy); end
        total++; if (hs != 36) begin bad++; $display("FAIL nopad_hs: got %0d want 36", hs); end
        total++; if (diff_data() != -1 || diff_en() != -1)
            begin bad++; $display("FAIL nopad_seq: diff data@%0d en@%0d want none", diff_data(), diff_en()); end
        total++; if (cap_en.size() != 36 || cap_en[21] !== 2'b01 || cap_en[22] !== 2'b11)
            begin bad++; $display("FAIL nopad_fill: got %0d emits want 36 with window valid from 22", cap_en.size()); end
        total++; if (done_cnt != 1) begin bad++; $display("FAIL nopad_done: got %0d want 1", done_cnt); end
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 1'b0, 1'b0, '0);
        drive(1, 1'b0, 1'b0, '0);
        test_reset();
        test_default_frame();
        test_backpressure();
        test_random_stalls();
        test_back_to_back();
        test_reset_mid_frame();
        test_nopad();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fmap_in_streamer.md
Name: fmap_in_streamer

Overview:
- Transmit-side partner of the input feature-map shift register.
- Takes raw unpadded feature-map pixels, one D-bit binary vector per pixel, from an upstream valid/ready source in raster order (row-major).
- Inserts zero padding and drives the shift register's data_in/in_en port.
- Asserts in_en[0] (shift) on every emitted pixel. Also asserts in_en[1] (window valid) once the shift register's buffer is full.

Parameters:
- H, 4: unpadded feature-map height.
- W, 4: unpadded feature-map width.
- D, 8: depth (channels); pixel width in bits.
- FH, 3: filter height.
- FW, 3: filter width.
- POOL_H, 2: pooling window height.
- POOL_W, 2: pooling window width.
- PAD, 1: zero-pad width on each border.
- STRIDE_H, 1: vertical conv stride.
- STRIDE_W, 1: horizontal conv stride.

Ports:
- clk, input, 1: clock; all state changes on rising edge.
- rst, input, 1: asynchronous, active-high reset.
- start, input, 1: begin one frame; sampled in IDLE only.
- src_valid, input, 1: upstream pixel valid.
- src_data, input, D: upstream pixel.
- src_ready, output, 1: streamer accepts src_data this cycle.
- in_en, output, 2: to shift register; bit0 = shift, bit1 = window valid.
- data_in, output, D: pixel to shift register.
- busy, output, 1: frame in progress (STREAM state).
- done, output, 1: one-cycle pulse after the last pixel is emitted.

Behaviour:
- Reset (rst=1, asynchronous):
  - state=IDLE; row, col and emit counters = 0.
  - in_en=2'b00, data_in=0, src_ready=0, busy=0, done=0.
  - Applies immediately, including mid-frame; the partial frame is abandoned and no done pulse is generated.
- Derived values:
  - HP = H+2*PAD, WP = W+2*PAD, TOTAL = HP*WP.
  - IN_WINDOW_H = (POOL_H-1)*STRIDE_H+FH.
  - FILL = WP*FH + IN_WINDOW_H.
- Counters:
  - row: clog2(HP) bits. col: clog2(WP) bits. emit: clog2(TOTAL+1) bits.
  - col wraps WP-1 -> 0 and increments row. No other wrap.
- Pad detection: position is pad when row<PAD, or row>=PAD+H, or col<PAD, or col>=PAD+W. Otherwise it is real.
- States:
  - IDLE: start=1 -> STREAM, counters cleared.
  - STREAM: loop while pixels remain. After the emit at (HP-1, WP-1) -> DONE.
  - DONE: done=1 for exactly one cycle, then -> IDLE. start is ignored in DONE and STREAM.
- src_ready:
  - Combinational: (state==STREAM) and current position is real.
  - Independent of src_valid.
- Emit condition (STREAM): pad position, or (real position and src_valid).
  - Pad emit: data_in<=0; src not consumed.
  - Real emit: data_in<=src_data; consumed via handshake.
  - On emit: in_en[0]<=1, in_en[1]<=(emit>=FILL), then emit, col and row advance.
- Stall: real position with src_valid=0 -> in_en<=2'b00, data_in holds, counters hold.
- Timing:
  - data_in and in_en are registered; one-cycle latency from the accept/pad decision.
  - With no stalls the frame is TOTAL contiguous cycles with in_en!=0.
- Outside emit cycles (IDLE, DONE, stall): in_en=2'b00.
- Pixel count per frame: exactly H*W source pixels consumed, TOTAL pixels emitted. Pixel order is preserved.

Decomposition:
- Shared package fmap_pkg holds:
  - Constant functions for HP, WP, TOTAL, IN_WINDOW_H, IN_WINDOW_W, FILL.
  - The state enum: IDLE, STREAM, DONE.
  - The same functions are used by the shift register, so both ends agree on FILL.
- One sub-module: fmap_pad_counter.
  - Contains the row/col raster counter, the is_pad flag and the last-position flag.
  - Ports: clk, rst, clear, advance.

Test Plan:
- Reset: hold rst=1 with random inputs -> in_en=00, data_in=0, src_ready=0, busy=0, done=0. Assert rst asynchronously between clock edges -> outputs clear before the next edge.
- Defaults, src_valid=1 constantly, data 1..16: 36 contiguous emits.
  - Emits 0-6 are zero; emit 7 carries 1; pixel 16 appears at emit 28.
  - in_en=01 for emits 0-21, in_en=11 for emits 22-35.
  - done pulses one cycle after the last emit; exactly 16 handshakes.
- Backpressure: drop src_valid for 3 cycles at source pixel 5 -> 3 cycles of in_en=00, counters frozen; the output sequence otherwise matches the previous test. src_valid low during pad positions -> no stall.
- start asserted during STREAM and DONE -> ignored; no restart. start the cycle after done -> second frame emits an identical 36-pixel sequence.
- Reset mid-frame at emit 10 -> outputs zero at once, no done pulse. A new start emits a full 36-pixel frame beginning at (0,0).
- PAD=0, H=W=6: src_ready is high for the whole frame, 36 handshakes, in_en[1] first set at emit 22 (FILL=22).
